ace_ccu_snoop_arbiter: RTL and testbench

Arbitrates snoop-initiating paths of the CCU onto the single snoop-interconnect issue slot. Each request carries a cache-line index. A request is granted only when no outstanding snoop targets the same line, and only while the conflict manager is not stalling. Every grant allocates a tracking slot, which stays live until the completion path releases it. The block sits between the master-path snoop request outputs and the snoop interconnect input.

---
 rtl/ace_ccu_snoop_arbiter_pkg.sv | 4 +
 rtl/ace_ccu_rr_pick.sv | 24 ++
 rtl/ace_ccu_snoop_arbiter.sv | 102 ++++++++++
 tb/tb_ace_ccu_snoop_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ace_ccu_snoop_arbiter_pkg.sv
// ace_ccu_snoop_arbiter_pkg: shared types for the snoop issue arbiter
package ace_ccu_snoop_arbiter_pkg;
  typedef enum logic {ST_IDLE, ST_OFFER} arb_state_e;
endpackage

// File: rtl/ace_ccu_rr_pick.sv
// ace_ccu_rr_pick: combinational round-robin first-one finder starting at a pointer
module ace_ccu_rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] mask_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] onehot_o,
  output logic [W-1:0] idx_o,
  output logic         found_o
);
  always_comb begin
    idx_o = '0;
    found_o = 1'b0;
    onehot_o = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (mask_i[(int'(ptr_i) + k) % N]) begin
        idx_o = W'((int'(ptr_i) + k) % N);
        found_o = 1'b1;
      end
    end
    if (found_o) onehot_o[idx_o] = 1'b1;
  end
endmodule

// File: rtl/ace_ccu_snoop_arbiter.sv
// ace_ccu_snoop_arbiter: line-conflict-aware round-robin snoop issue arbiter with slot tracking
module ace_ccu_snoop_arbiter
  import ace_ccu_snoop_arbiter_pkg::*;
#(
  parameter int NoReq          = 4,
  parameter int CmAddrWidth    = 8,
  parameter int MaxOutstanding = 4,
  parameter int IdxWidth       = $clog2(NoReq),
  parameter int SlotWidth      = $clog2(MaxOutstanding),
  parameter int CntWidth       = $clog2(MaxOutstanding + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NoReq-1:0]             req_valid_i,
  input  logic [NoReq*CmAddrWidth-1:0] req_addr_i,
  output logic [NoReq-1:0]             req_ready_o,
  input  logic                         cm_stall_i,
  output logic                         grant_valid_o,
  input  logic                         grant_ready_i,
  output logic [IdxWidth-1:0]          grant_idx_o,
  output logic [CmAddrWidth-1:0]       grant_addr_o,
  output logic [SlotWidth-1:0]         grant_slot_o,
  input  logic                         done_valid_i,
  input  logic [SlotWidth-1:0]         done_slot_i,
  output logic [CntWidth-1:0]          busy_o,
  output logic                         err_o
);
  typedef logic [CmAddrWidth-1:0] line_idx_t;
  typedef logic [SlotWidth-1:0] slot_t;
  typedef struct packed {
    logic      valid;
    line_idx_t addr;
  } entry_t;
  arb_state_e state_q, state_d;
  entry_t [MaxOutstanding-1:0] tbl_q, tbl_d;
  logic [IdxWidth-1:0] rr_ptr_q, rr_ptr_d, idx_q, idx_d, win_idx;
  line_idx_t addr_q, addr_d, win_addr;
  slot_t slot_q, slot_d, free_slot;
  logic [CntWidth-1:0] busy_q, busy_d;
  logic err_q, err_d;
  logic [NoReq-1:0] hit, eligible;
  logic can_capture, capture, release_ok;
  always_comb begin
    hit = '0;
    free_slot = '0;
    for (int i = 0; i < NoReq; i++)
      for (int e = 0; e < MaxOutstanding; e++)
        hit[i] = hit[i] | (tbl_q[e].valid && tbl_q[e].addr == req_addr_i[i*CmAddrWidth +: CmAddrWidth]);
    for (int e = MaxOutstanding - 1; e >= 0; e--)
      free_slot = tbl_q[e].valid ? free_slot : slot_t'(e);
    can_capture = !cm_stall_i && busy_q != CntWidth'(MaxOutstanding) && (state_q == ST_IDLE || grant_ready_i);
    eligible = req_valid_i & ~hit & {NoReq{can_capture}};
  end
  ace_ccu_rr_pick #(.N(NoReq), .W(IdxWidth)) u_pick (
    .mask_i  (eligible),
    .ptr_i   (rr_ptr_q),
    .onehot_o(req_ready_o),
    .idx_o   (win_idx),
    .found_o (capture)
  );
  always_comb begin
    win_addr = req_addr_i[win_idx*CmAddrWidth +: CmAddrWidth];
    release_ok = done_valid_i && tbl_q[done_slot_i].valid;
    err_d = done_valid_i && !tbl_q[done_slot_i].valid;
    tbl_d = tbl_q;
    if (release_ok) tbl_d[done_slot_i].valid = 1'b0;
    if (capture) tbl_d[free_slot] = '{valid: 1'b1, addr: win_addr};
    busy_d = busy_q + CntWidth'(capture) - CntWidth'(release_ok);
    state_d = capture ? ST_OFFER : (grant_ready_i ? ST_IDLE : state_q);
    rr_ptr_d = capture ? (win_idx == IdxWidth'(NoReq - 1) ? '0 : win_idx + 1'b1) : rr_ptr_q;
    idx_d = capture ? win_idx : idx_q;
    addr_d = capture ? win_addr : addr_q;
    slot_d = capture ? free_slot : slot_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      tbl_q <= '0;
      rr_ptr_q <= '0;
      idx_q <= '0;
      addr_q <= '0;
      slot_q <= '0;
      busy_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tbl_q <= tbl_d;
      rr_ptr_q <= rr_ptr_d;
      idx_q <= idx_d;
      addr_q <= addr_d;
      slot_q <= slot_d;
      busy_q <= busy_d;
      err_q <= err_d;
    end
  end
  assign grant_valid_o = state_q == ST_OFFER;
  assign grant_idx_o = idx_q;
  assign grant_addr_o = addr_q;
  assign grant_slot_o = slot_q;
  assign busy_o = busy_q;
  assign err_o = err_q;
endmodule

// File: tb/tb_ace_ccu_snoop_arbiter.sv
// tb_ace_ccu_snoop_arbiter: vector, directed and randomized checks against a reference model
module tb_ace_ccu_snoop_arbiter;
  logic clk = 1'b0;
  logic rst, st, gr, dv;
  logic [3:0] v;
  logic [31:0] a;
  logic [1:0] ds;
  logic [3:0] rdy;
  logic gv, err;
  logic [1:0] gidx, gslot;
  logic [7:0] gaddr;
  logic [2:0] busy;
  int checks = 0, errors = 0;
  bit chk_en = 0;
  bit [3:0] m_valid;
  logic [7:0] m_addr [4];
  int m_rr, m_gidx, m_gslot;
  logic [7:0] m_gaddr;
  bit m_offer, m_err;
  typedef struct {
    logic rst;
    logic [3:0] v;
    logic [31:0] a;
    logic gr, st, dv;
    logic [1:0] ds;
    logic [3:0] rdy;
    logic gv;
    logic [1:0] gi;
    logic [2:0] bz;
  } vec_t;
  vec_t vq[$];

  ace_ccu_snoop_arbiter dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(v), .req_addr_i(a), .req_ready_o(rdy),
    .cm_stall_i(st), .grant_valid_o(gv), .grant_ready_i(gr), .grant_idx_o(gidx),
    .grant_addr_o(gaddr), .grant_slot_o(gslot), .done_valid_i(dv), .done_slot_i(ds),
    .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", n, $time, act, exp);
    end
  endtask

  function automatic bit m_hit(input logic [7:0] ad);
    for (int e = 0; e < 4; e++) if (m_valid[e] && m_addr[e] == ad) return 1;
    return 0;
  endfunction

  function automatic int m_winner();
    if (st || $countones(m_valid) == 4 || (m_offer && !gr)) return -1;
    for (int k = 0; k < 4; k++) begin
      int j = (m_rr + k) % 4;
      if (v[j] && !m_hit(a[j*8 +: 8])) return j;
    end
    return -1;
  endfunction

  task automatic m_check();
    int w = m_winner();
    chk("req_ready", 32'(rdy), w < 0 ? 0 : 1 << w);
    chk("grant_valid", 32'(gv), 32'(m_offer));
    chk("grant_idx", 32'(gidx), m_gidx);
    chk("grant_addr", 32'(gaddr), 32'(m_gaddr));
    chk("grant_slot", 32'(gslot), m_gslot);
    chk("busy", 32'(busy), $countones(m_valid));
    chk("err", 32'(err), 32'(m_err));
  endtask

  task automatic m_update();
    int w, fr;
    if (rst) begin
      m_valid = 0; m_rr = 0; m_offer = 0; m_gidx = 0; m_gaddr = 0; m_gslot = 0; m_err = 0;
      for (int e = 0; e < 4; e++) m_addr[e] = 0;
      return;
    end
    w = m_winner();
    fr = 0;
    for (int e = 3; e >= 0; e--) if (!m_valid[e]) fr = e;
    m_err = dv && !m_valid[ds];
    if (dv) m_valid[ds] = 0;
    if (w >= 0) begin
      m_valid[fr] = 1;
      m_addr[fr] = a[w*8 +: 8];
      m_gidx = w; m_gaddr = a[w*8 +: 8]; m_gslot = fr;
      m_rr = (w + 1) % 4;
      m_offer = 1;
    end else if (gr) m_offer = 0;
  endtask

  task automatic drive(input logic r, input logic [3:0] vv, input logic [31:0] aa,
                       input logic g, input logic s, input logic d, input logic [1:0] dsl);
    rst = r; v = vv; a = aa; gr = g; st = s; dv = d; ds = dsl;
    #1;
    if (chk_en) m_check();
  endtask

  task automatic adv();
    @(posedge clk);
    m_update();
    @(negedge clk);
  endtask

  task automatic add(input logic r, input logic [3:0] vv, input logic [31:0] aa, input logic g,
                     input logic s, input logic d, input logic [1:0] dsl,
                     input logic [3:0] er, input logic eg, input logic [1:0] ei, input logic [2:0] eb);
    vq.push_back('{r, vv, aa, g, s, d, dsl, er, eg, ei, eb});
  endtask

  initial begin
    logic [31:0] ra;
    drive(1, 0, 0, 0, 0, 0, 0);
    adv();
    chk_en = 1;
    add(0, 4'h0, 32'h0, 0, 0, 0, 0, 4'h0, 0, 0, 0);
    add(0, 4'h1, 32'h12, 1, 0, 0, 0, 4'h1, 0, 0, 0);
    add(0, 4'h0, 32'h0, 1, 0, 0, 0, 4'h0, 1, 0, 1);
    add(0, 4'h0, 32'h0, 0, 0, 1, 0, 4'h0, 0, 0, 1);
    add(0, 4'h0, 32'h0, 0, 0, 0, 0, 4'h0, 0, 0, 0);
    add(1, 4'h0, 32'h0, 0, 0, 0, 0, 4'h0, 0, 0, 0);
    add(0, 4'hF, 32'h33221110, 1, 0, 0, 0, 4'h1, 0, 0, 0);
    add(0, 4'hF, 32'h33221110, 1, 0, 0, 0, 4'h2, 1, 0, 1);
    add(0, 4'hF, 32'h33221110, 1, 0, 0, 0, 4'h4, 1, 1, 2);
    add(0, 4'hF, 32'h33221110, 1, 0, 0, 0, 4'h8, 1, 2, 3);
    add(0, 4'hF, 32'h33221110, 1, 0, 0, 0, 4'h0, 1, 3, 4);
    add(0, 4'h0, 32'h0, 1, 0, 0, 0, 4'h0, 0, 3, 4);
    add(0, 4'h0, 32'h0, 0, 0, 1, 0, 4'h0, 0, 3, 4);
    add(0, 4'h0, 32'h0, 0, 0, 1, 1, 4'h0, 0, 3, 3);
    add(0, 4'h0, 32'h0, 0, 0, 1, 2, 4'h0, 0, 3, 2);
    add(0, 4'h0, 32'h0, 0, 0, 1, 3, 4'h0, 0, 3, 1);
    add(0, 4'h0, 32'h0, 0, 0, 0, 0, 4'h0, 0, 3, 0);
    add(0, 4'h6, 32'h00404000, 1, 0, 0, 0, 4'h2, 0, 3, 0);
    add(0, 4'h6, 32'h00404000, 1, 0, 0, 0, 4'h0, 1, 1, 1);
    add(0, 4'h6, 32'h00404000, 1, 0, 1, 0, 4'h0, 0, 1, 1);
    add(0, 4'h6, 32'h00404000, 1, 0, 0, 0, 4'h4, 0, 1, 0);
    add(0, 4'h0, 32'h0, 1, 0, 0, 0, 4'h0, 1, 2, 1);
    add(0, 4'h0, 32'h0, 0, 0, 1, 0, 4'h0, 0, 2, 1);
    add(0, 4'h0, 32'h0, 0, 0, 0, 0, 4'h0, 0, 2, 0);
    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].v, vq[i].a, vq[i].gr, vq[i].st, vq[i].dv, vq[i].ds);
      chk($sformatf("vec%0d_rdy", i), 32'(rdy), 32'(vq[i].rdy));
      chk($sformatf("vec%0d_gv", i), 32'(gv), 32'(vq[i].gv));
      chk($sformatf("vec%0d_gidx", i), 32'(gidx), 32'(vq[i].gi));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vq[i].bz));
      adv();
    end
    drive(0, 4'h1, 32'h55, 0, 0, 0, 0);
    chk("bp_first_rdy", 32'(rdy), 1);
    adv();
    for (int i = 0; i < 5; i++) begin
      drive(0, 4'h2, 32'h6655, 0, 0, 0, 0);
      chk("bp_hold_rdy", 32'(rdy), 0);
      chk("bp_hold_gv", 32'(gv), 1);
      chk("bp_hold_addr", 32'(gaddr), 32'h55);
      chk("bp_hold_idx", 32'(gidx), 0);
      adv();
    end
    drive(0, 4'h2, 32'h6655, 1, 0, 0, 0);
    chk("bp_release_rdy", 32'(rdy), 2);
    adv();
    drive(0, 4'h0, 32'h0, 1, 0, 0, 0);
    chk("bp_next_gv", 32'(gv), 1);
    chk("bp_next_addr", 32'(gaddr), 32'h66);
    chk("bp_next_slot", 32'(gslot), 1);
    adv();
    drive(0, 0, 0, 0, 0, 1, 0); adv();
    drive(0, 0, 0, 0, 0, 1, 1); adv();
    drive(0, 4'h4, 32'h00770000, 1, 0, 0, 0); adv();
    drive(0, 4'h4, 32'h00780000, 1, 1, 0, 0);
    chk("stall_rdy", 32'(rdy), 0);
    chk("stall_gv", 32'(gv), 1);
    adv();
    drive(0, 4'h4, 32'h00780000, 1, 1, 0, 0);
    chk("stall_offer_done", 32'(gv), 0);
    adv();
    drive(0, 0, 0, 0, 0, 1, 0); adv();
    for (int i = 0; i < 4; i++) begin
      drive(0, 4'(1 << i), 32'hA3A2A1A0, 1, 0, 0, 0);
      adv();
    end
    drive(0, 4'h1, 32'hB0, 1, 0, 1, 2);
    chk("full_busy", 32'(busy), 4);
    chk("full_rdy", 32'(rdy), 0);
    adv();
    drive(0, 4'h1, 32'hB0, 1, 0, 0, 0);
    chk("full_after_rdy", 32'(rdy), 1);
    chk("full_after_busy", 32'(busy), 3);
    adv();
    drive(0, 0, 0, 1, 0, 0, 0);
    chk("full_reuse_slot", 32'(gslot), 2);
    chk("full_reuse_addr", 32'(gaddr), 32'hB0);
    adv();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 1, 2'(i));
      adv();
    end
    drive(0, 0, 0, 0, 0, 1, 3); adv();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("err_pulse", 32'(err), 1);
    chk("err_busy", 32'(busy), 0);
    adv();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("err_clear", 32'(err), 0);
    adv();
    drive(0, 4'h1, 32'hC0, 0, 0, 0, 0); adv();
    drive(1, 0, 0, 0, 0, 0, 0);
    chk("rst_pre_gv", 32'(gv), 1);
    adv();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("rst_post_gv", 32'(gv), 0);
    chk("rst_post_busy", 32'(busy), 0);
    adv();
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 4; k++) ra[k*8 +: 8] = 8'($urandom_range(0, 5));
      drive($urandom_range(0, 99) == 0, 4'($urandom), ra, $urandom_range(0, 3) != 0,
            $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0, 2'($urandom));
      adv();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
